// File: rtl/occupancy_ctrl_pkg.sv
// Shared types and helpers for the occupancy controller.
// Door FSM state encoding, width helper, popcount.
package occupancy_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEEN_OUT,
    SEEN_IN,
    WAIT_CLR
  } door_state_t;

  localparam int TMO_CYC_DEF  = 64;
  localparam int HOLD_CYC_DEF = 16;
  localparam int TMO_W  = $clog2(TMO_CYC_DEF + 1);
  localparam int HOLD_W = $clog2(HOLD_CYC_DEF + 1);

  // Bits needed to hold 0..n, never less than one.
  function automatic int width_of(input int n);
    return (n > 0) ? $clog2(n + 1) : 1;
  endfunction

  function automatic logic [5:0] popcount(
    input logic [31:0] v
  );
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 32; i++)
      c = c + 6'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/occupancy_ctrl_if.sv
// Sensor / status bundle of the occupancy controller.
// master: sensor side (drives x_out, x_in, clr); slave: controller.
interface occupancy_ctrl_if #(
  parameter int N_DOORS = 2,
  parameter int CNT_W   = 8
);

  logic [N_DOORS-1:0] x_out;
  logic [N_DOORS-1:0] x_in;
  logic               clr;
  logic [CNT_W-1:0]   occ;
  logic               full;
  logic               lamp;
  logic [N_DOORS-1:0] enter_evt;
  logic [N_DOORS-1:0] exit_evt;
  logic [N_DOORS-1:0] tmo;
  logic               sat;

  modport master (
    output x_out, x_in, clr,
    input  occ, full, lamp,
    input  enter_evt, exit_evt,
    input  tmo, sat
  );

  modport slave (
    input  x_out, x_in, clr,
    output occ, full, lamp,
    output enter_evt, exit_evt,
    output tmo, sat
  );

endinterface

// File: rtl/occupancy_ctrl_door_fsm.sv
// One doorway: direction decode FSM, crossing timeout, event regs.
// Ports: clk, rst_n, x_out, x_in in; enter_evt, exit_evt, tmo pulses out.
module door_fsm
  import occupancy_pkg::*;
#(
  parameter int TMO_CYC = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic x_out,
  input  logic x_in,
  output logic enter_evt,
  output logic exit_evt,
  output logic tmo
);

  localparam int TW = width_of(TMO_CYC);
  localparam logic [TW-1:0] TLAST =
    TW'(TMO_CYC - 1);

  door_state_t   st;
  logic [TW-1:0] tmr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st        <= IDLE;
      tmr       <= '0;
      enter_evt <= 1'b0;
      exit_evt  <= 1'b0;
      tmo       <= 1'b0;
    end else begin
      enter_evt <= 1'b0;
      exit_evt  <= 1'b0;
      tmo       <= 1'b0;
      unique case (st)
        IDLE: begin
          // Only path into SEEN_*, so the
          // timer is zero on every entry.
          tmr <= '0;
          if (x_out && !x_in)
            st <= SEEN_OUT;
          else if (x_in && !x_out)
            st <= SEEN_IN;
          else if (x_out && x_in)
            st <= WAIT_CLR;
        end
        SEEN_OUT: begin
          if (x_in) begin
            st        <= WAIT_CLR;
            enter_evt <= 1'b1;
          end else if (!x_out) begin
            st <= IDLE;
          end else if (tmr == TLAST) begin
            st  <= WAIT_CLR;
            tmo <= 1'b1;
          end else begin
            tmr <= tmr + TW'(1);
          end
        end
        SEEN_IN: begin
          if (x_out) begin
            st       <= WAIT_CLR;
            exit_evt <= 1'b1;
          end else if (!x_in) begin
            st <= IDLE;
          end else if (tmr == TLAST) begin
            st  <= WAIT_CLR;
            tmo <= 1'b1;
          end else begin
            tmr <= tmr + TW'(1);
          end
        end
        WAIT_CLR: begin
          if (!x_out && !x_in)
            st <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/occupancy_ctrl.sv
// Room occupancy counter and lamp hold-off over N door FSMs.
// Ports: clk, rst_n, bus (slave: sensors/clr in; occ/full/lamp/pulses out).
module occupancy_ctrl
  import occupancy_pkg::*;
#(
  parameter int N_DOORS  = 2,
  parameter int CNT_W    = 8,
  parameter int MAX_OCC  = 255,
  parameter int HOLD_CYC = 16,
  parameter int TMO_CYC  = 64
) (
  input logic clk,
  input logic rst_n,
  occupancy_ctrl_if.slave bus
);

  localparam int W  = CNT_W + 2;
  localparam int HW = width_of(HOLD_CYC);
  localparam logic signed [W-1:0] MAX_S =
    W'(MAX_OCC);
  localparam logic [CNT_W-1:0] MAX_U =
    CNT_W'(MAX_OCC);
  localparam logic [HW-1:0] HOLD_V =
    HW'(HOLD_CYC);

  logic [N_DOORS-1:0] enter_q;
  logic [N_DOORS-1:0] exit_q;
  logic [N_DOORS-1:0] tmo_q;

  for (genvar g = 0; g < N_DOORS; g++) begin : g_door
    door_fsm #(
      .TMO_CYC (TMO_CYC)
    ) u_door (
      .clk       (clk),
      .rst_n     (rst_n),
      .x_out     (bus.x_out[g]),
      .x_in      (bus.x_in[g]),
      .enter_evt (enter_q[g]),
      .exit_evt  (exit_q[g]),
      .tmo       (tmo_q[g])
    );
  end

  logic [CNT_W-1:0]     occ_q;
  logic [CNT_W-1:0]     occ_d;
  logic                 sat_q;
  logic                 sat_d;
  logic [HW-1:0]        hold_q;
  logic                 lamp_q;
  logic signed [W-1:0]  n_en;
  logic signed [W-1:0]  n_ex;
  logic signed [W-1:0]  sum;

  // Enters and exits from all doors net out
  // in one signed update, then clamp.
  always_comb begin
    n_en  = W'(popcount(32'(enter_q)));
    n_ex  = W'(popcount(32'(exit_q)));
    sum   = $signed({2'b00, occ_q}) + n_en - n_ex;
    occ_d = sum[CNT_W-1:0];
    sat_d = 1'b0;
    if (sum[W-1]) begin
      occ_d = '0;
      sat_d = 1'b1;
    end else if (sum > MAX_S) begin
      occ_d = MAX_U;
      sat_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ_q  <= '0;
      sat_q  <= 1'b0;
      hold_q <= '0;
      lamp_q <= 1'b0;
    end else begin
      if (bus.clr) begin
        occ_q <= '0;
        sat_q <= 1'b0;
      end else begin
        occ_q <= occ_d;
        sat_q <= sat_d;
      end
      // Reload while occupied, drain once empty.
      if (occ_q != '0)
        hold_q <= HOLD_V;
      else if (hold_q != '0)
        hold_q <= hold_q - HW'(1);
      lamp_q <= (occ_q != '0) || (hold_q != '0);
    end
  end

  assign bus.occ       = occ_q;
  assign bus.full      = (occ_q == MAX_U);
  assign bus.lamp      = lamp_q;
  assign bus.sat       = sat_q;
  assign bus.enter_evt = enter_q;
  assign bus.exit_evt  = exit_q;
  assign bus.tmo       = tmo_q;

endmodule

// File: tb/tb_occupancy_ctrl.sv
// Directed bench for occupancy_ctrl.
// dut_a: MAX 255/HOLD 4/TMO 8; dut_b: MAX 3.
module tb_occupancy_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  occupancy_ctrl_if #(.N_DOORS(2), .CNT_W(8)) ia ();
  occupancy_ctrl_if #(.N_DOORS(2), .CNT_W(8)) ib ();

  occupancy_ctrl #(
    .N_DOORS(2), .CNT_W(8), .MAX_OCC(255),
    .HOLD_CYC(4), .TMO_CYC(8)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ia.slave)
  );

  occupancy_ctrl #(
    .N_DOORS(2), .CNT_W(8), .MAX_OCC(3),
    .HOLD_CYC(4), .TMO_CYC(8)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ib.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit s, input int d,
                       input logic o, input logic i);
    if (s) begin
      ib.x_out[d] = o;
      ib.x_in[d]  = i;
    end else begin
      ia.x_out[d] = o;
      ia.x_in[d]  = i;
    end
  endtask

  // Full entry; returns sat/occ at the update edge.
  task automatic do_enter(input bit s, input int d,
                          input int nout,
                          output logic sat_o,
                          output logic [7:0] occ_o);
    drive(s, d, 1'b1, 1'b0);
    repeat (nout) tick();
    drive(s, d, 1'b1, 1'b1); tick();
    drive(s, d, 1'b0, 1'b1); tick();
    sat_o = s ? ib.sat : ia.sat;
    occ_o = s ? ib.occ : ia.occ;
    drive(s, d, 1'b0, 1'b0); tick();
  endtask

  task automatic do_exit(input bit s, input int d,
                         output logic sat_o,
                         output logic [7:0] occ_o);
    drive(s, d, 1'b0, 1'b1); tick();
    drive(s, d, 1'b1, 1'b1); tick();
    drive(s, d, 1'b1, 1'b0); tick();
    sat_o = s ? ib.sat : ia.sat;
    occ_o = s ? ib.occ : ia.occ;
    drive(s, d, 1'b0, 1'b0); tick();
  endtask

  task automatic test_reset();
    ia.x_out = '0; ia.x_in = '0; ia.clr = 1'b0;
    ib.x_out = '0; ib.x_in = '0; ib.clr = 1'b0;
    rst_n = 1'b0;
    tick(); tick();
    n_cmp++; if (ia.occ !== 8'd0) begin n_bad++;
      $display("FAIL rst_occ got %0d want 0", ia.occ); end
    n_cmp++; if (ia.lamp !== 1'b0) begin n_bad++;
      $display("FAIL rst_lamp got %b want 0", ia.lamp); end
    n_cmp++; if ({ia.enter_evt, ia.exit_evt, ia.tmo, ia.sat} !== 7'd0) begin n_bad++;
      $display("FAIL rst_pulses got %b want 0",
               {ia.enter_evt, ia.exit_evt, ia.tmo, ia.sat}); end
    n_cmp++; if (ib.full !== 1'b0) begin n_bad++;
      $display("FAIL rst_full got %b want 0", ib.full); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_enter();
    drive(0, 0, 1'b1, 1'b0); tick();
    n_cmp++; if (ia.enter_evt !== 2'b00) begin n_bad++;
      $display("FAIL ent_early got %b want 00", ia.enter_evt); end
    tick();
    drive(0, 0, 1'b1, 1'b1); tick();
    n_cmp++; if (ia.enter_evt !== 2'b01) begin n_bad++;
      $display("FAIL ent_evt got %b want 01", ia.enter_evt); end
    n_cmp++; if (ia.occ !== 8'd0) begin n_bad++;
      $display("FAIL ent_occ0 got %0d want 0", ia.occ); end
    drive(0, 0, 1'b0, 1'b1); tick();
    n_cmp++; if (ia.occ !== 8'd1 || ia.enter_evt !== 2'b00) begin n_bad++;
      $display("FAIL ent_occ1 got %0d/%b want 1/00",
               ia.occ, ia.enter_evt); end
    n_cmp++; if (ia.lamp !== 1'b0) begin n_bad++;
      $display("FAIL ent_lamp_early got %b want 0", ia.lamp); end
    drive(0, 0, 1'b0, 1'b0); tick();
    n_cmp++; if (ia.lamp !== 1'b1) begin n_bad++;
      $display("FAIL ent_lamp got %b want 1", ia.lamp); end
  endtask

  task automatic test_hold();
    logic s_o;
    logic [7:0] o_o;
    logic [1:0] seq [8];
    seq = '{2'b01, 2'b11, 2'b10, 2'b00,
            2'b10, 2'b11, 2'b01, 2'b00};
    drive(0, 0, 1'b0, 1'b1); tick();
    drive(0, 0, 1'b1, 1'b1); tick();
    n_cmp++; if (ia.exit_evt !== 2'b01) begin n_bad++;
      $display("FAIL hold_exit got %b want 01", ia.exit_evt); end
    drive(0, 0, 1'b1, 1'b0); tick();
    n_cmp++; if (ia.occ !== 8'd0) begin n_bad++;
      $display("FAIL hold_occ got %0d want 0", ia.occ); end
    drive(0, 0, 1'b0, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      n_cmp++; if (ia.lamp !== 1'b1) begin n_bad++;
        $display("FAIL hold_on%0d got %b want 1", k, ia.lamp); end
    end
    tick();
    n_cmp++; if (ia.lamp !== 1'b0) begin n_bad++;
      $display("FAIL hold_off got %b want 0", ia.lamp); end
    do_enter(0, 0, 1, s_o, o_o);
    n_cmp++; if (o_o !== 8'd1) begin n_bad++;
      $display("FAIL hold_reocc got %0d want 1", o_o); end
    for (int j = 0; j < 14; j++) begin
      if (j < 8) drive(0, 0, seq[j][1], seq[j][0]);
      tick();
      n_cmp++; if (ia.lamp !== 1'b1) begin n_bad++;
        $display("FAIL reent_lamp%0d got %b want 1", j, ia.lamp); end
    end
    n_cmp++; if (ia.occ !== 8'd1) begin n_bad++;
      $display("FAIL reent_occ got %0d want 1", ia.occ); end
  endtask

  task automatic test_backout();
    drive(0, 1, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++; if ({ia.enter_evt, ia.exit_evt, ia.tmo} !== 6'd0) begin n_bad++;
        $display("FAIL back_p%0d got %b want 0", k,
                 {ia.enter_evt, ia.exit_evt, ia.tmo}); end
    end
    drive(0, 1, 1'b0, 1'b0); tick(); tick();
    n_cmp++; if (ia.occ !== 8'd1) begin n_bad++;
      $display("FAIL back_occ got %0d want 1", ia.occ); end
    drive(0, 1, 1'b1, 1'b1); tick();
    n_cmp++; if (ia.enter_evt !== 2'b00 || ia.exit_evt !== 2'b00) begin n_bad++;
      $display("FAIL amb_evt got %b/%b want 00/00",
               ia.enter_evt, ia.exit_evt); end
    drive(0, 1, 1'b0, 1'b1); tick();
    drive(0, 1, 1'b1, 1'b1); tick();
    n_cmp++; if (ia.exit_evt !== 2'b00) begin n_bad++;
      $display("FAIL amb_noexit got %b want 00", ia.exit_evt); end
    drive(0, 1, 1'b0, 1'b0); tick(); tick();
    n_cmp++; if (ia.occ !== 8'd1) begin n_bad++;
      $display("FAIL amb_occ got %0d want 1", ia.occ); end
  endtask

  task automatic test_same_cycle();
    logic s_o;
    logic [7:0] o_o;
    do_enter(0, 0, 1, s_o, o_o);
    n_cmp++; if (o_o !== 8'd2) begin n_bad++;
      $display("FAIL same_pre got %0d want 2", o_o); end
    drive(0, 0, 1'b1, 1'b0);
    drive(0, 1, 1'b0, 1'b1); tick();
    drive(0, 0, 1'b1, 1'b1);
    drive(0, 1, 1'b1, 1'b1); tick();
    n_cmp++; if (ia.enter_evt !== 2'b01 || ia.exit_evt !== 2'b10) begin n_bad++;
      $display("FAIL same_evt got %b/%b want 01/10",
               ia.enter_evt, ia.exit_evt); end
    drive(0, 0, 1'b0, 1'b1);
    drive(0, 1, 1'b1, 1'b0); tick();
    n_cmp++; if (ia.occ !== 8'd2 || ia.sat !== 1'b0) begin n_bad++;
      $display("FAIL same_occ got %0d/%b want 2/0",
               ia.occ, ia.sat); end
    drive(0, 0, 1'b0, 1'b0);
    drive(0, 1, 1'b0, 1'b0); tick();
  endtask

  task automatic test_sat();
    logic s_o;
    logic [7:0] o_o;
    for (int k = 1; k <= 3; k++) begin
      do_enter(1, 0, 2, s_o, o_o);
      n_cmp++; if (o_o !== 8'(k) || s_o !== 1'b0) begin n_bad++;
        $display("FAIL sat_up%0d got %0d/%b want %0d/0",
                 k, o_o, s_o, k); end
    end
    n_cmp++; if (ib.full !== 1'b1) begin n_bad++;
      $display("FAIL sat_full got %b want 1", ib.full); end
    do_enter(1, 1, 1, s_o, o_o);
    n_cmp++; if (o_o !== 8'd3 || s_o !== 1'b1) begin n_bad++;
      $display("FAIL sat_hi got %0d/%b want 3/1", o_o, s_o); end
    n_cmp++; if (ib.sat !== 1'b0) begin n_bad++;
      $display("FAIL sat_pulse got %b want 0", ib.sat); end
    for (int k = 2; k >= 0; k--) begin
      do_exit(1, 0, s_o, o_o);
      n_cmp++; if (o_o !== 8'(k) || s_o !== 1'b0) begin n_bad++;
        $display("FAIL sat_dn%0d got %0d/%b want %0d/0",
                 k, o_o, s_o, k); end
    end
    n_cmp++; if (ib.full !== 1'b0) begin n_bad++;
      $display("FAIL sat_nfull got %b want 0", ib.full); end
    do_exit(1, 1, s_o, o_o);
    n_cmp++; if (o_o !== 8'd0 || s_o !== 1'b1) begin n_bad++;
      $display("FAIL sat_lo got %0d/%b want 0/1", o_o, s_o); end
    do_enter(1, 0, 1, s_o, o_o);
    drive(1, 0, 1'b1, 1'b0); tick();
    drive(1, 0, 1'b1, 1'b1); tick();
    ib.clr = 1'b1;
    drive(1, 0, 1'b0, 1'b1); tick();
    n_cmp++; if (ib.occ !== 8'd0 || ib.sat !== 1'b0) begin n_bad++;
      $display("FAIL clr_occ got %0d/%b want 0/0",
               ib.occ, ib.sat); end
    ib.clr = 1'b0;
    drive(1, 0, 1'b0, 1'b0); tick();
    n_cmp++; if (ib.occ !== 8'd0) begin n_bad++;
      $display("FAIL clr_hold got %0d want 0", ib.occ); end
  endtask

  task automatic test_timeout();
    drive(0, 1, 1'b1, 1'b0); tick();
    for (int k = 1; k <= 7; k++) begin
      tick();
      n_cmp++; if (ia.tmo !== 2'b00) begin n_bad++;
        $display("FAIL tmo_early%0d got %b want 00", k, ia.tmo); end
    end
    tick();
    n_cmp++; if (ia.tmo !== 2'b10 || ia.enter_evt !== 2'b00) begin n_bad++;
      $display("FAIL tmo_hit got %b/%b want 10/00",
               ia.tmo, ia.enter_evt); end
    tick();
    n_cmp++; if (ia.tmo !== 2'b00) begin n_bad++;
      $display("FAIL tmo_once got %b want 00", ia.tmo); end
    drive(0, 1, 1'b1, 1'b1); tick();
    n_cmp++; if (ia.enter_evt !== 2'b00) begin n_bad++;
      $display("FAIL tmo_noent got %b want 00", ia.enter_evt); end
    drive(0, 1, 1'b0, 1'b1); tick();
    drive(0, 1, 1'b1, 1'b1); tick();
    n_cmp++; if (ia.exit_evt !== 2'b00) begin n_bad++;
      $display("FAIL tmo_wait got %b want 00", ia.exit_evt); end
    drive(0, 1, 1'b0, 1'b0); tick();
    drive(0, 1, 1'b0, 1'b1); tick();
    drive(0, 1, 1'b1, 1'b1); tick();
    n_cmp++; if (ia.exit_evt !== 2'b10) begin n_bad++;
      $display("FAIL tmo_idle got %b want 10", ia.exit_evt); end
    drive(0, 1, 1'b1, 1'b0); tick();
    drive(0, 1, 1'b0, 1'b0); tick();
  endtask

  task automatic test_reset_mid();
    logic s_o;
    logic [7:0] o_o;
    repeat (4) do_enter(0, 0, 1, s_o, o_o);
    n_cmp++; if (ia.occ !== 8'd5) begin n_bad++;
      $display("FAIL mid_pre got %0d want 5", ia.occ); end
    drive(0, 0, 1'b1, 1'b0); tick();
    rst_n = 1'b0; tick();
    n_cmp++; if (ia.occ !== 8'd0 || ia.lamp !== 1'b0) begin n_bad++;
      $display("FAIL mid_rst got %0d/%b want 0/0",
               ia.occ, ia.lamp); end
    rst_n = 1'b1;
    drive(0, 0, 1'b0, 1'b1); tick();
    n_cmp++; if (ia.enter_evt !== 2'b00) begin n_bad++;
      $display("FAIL mid_idle got %b want 00", ia.enter_evt); end
    drive(0, 0, 1'b1, 1'b1); tick();
    n_cmp++; if (ia.exit_evt !== 2'b01) begin n_bad++;
      $display("FAIL mid_seenin got %b want 01", ia.exit_evt); end
    drive(0, 0, 1'b0, 1'b0); tick(); tick();
  endtask

  initial begin
    test_reset();
    test_enter();
    test_hold();
    test_backout();
    test_same_cycle();
    test_sat();
    test_timeout();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
